seq_magnitude_comparator: RTL and testbench
===========================================

Name: seq_magnitude_comparator

Overview:
- Multi-cycle, parametrised magnitude comparator for wide operands. Compares CHUNK bits per clock, most-significant chunk first, and stops early at the first differing chunk.
- Supports unsigned and two's-complement signed comparison, selected per transaction.
- Uses a valid/ready handshake on both the operand and result sides. Serves datapaths where a full-width single-cycle comparator would miss timing or cost too much area.

Parameters:
- WIDTH, 32, operand width in bits; must be an integer multiple of CHUNK.
- CHUNK, 8, bits compared per cycle; 1 <= CHUNK <= WIDTH.
- NCHUNK, WIDTH/CHUNK, derived localparam: number of chunks (latency bound).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous abort: returns the block to IDLE and discards any operation or result.
- in_valid  in  1  operands and mode are valid.
- in_ready  out  1  block can accept operands (high only in IDLE).
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- signed_mode  in  1  1 = compare as two's-complement, 0 = unsigned.
- out_valid  out  1  result valid (high only in DONE).
- out_ready  in  1  consumer accepts the result.
- agtb  out  1  A > B.
- altb  out  1  A < B.
- aeqb  out  1  A == B.
- busy  out  1  high in CMP or DONE.
- cycles  out  $clog2(NCHUNK+1)  number of chunks examined for the current result (1..NCHUNK).

Behaviour:
- Reset (reset_n low, asynchronous): state=IDLE; in_ready=1; out_valid=0; agtb=altb=aeqb=0; busy=0; cycles=0; internal operand registers and chunk index cleared.
- States: IDLE, CMP, DONE.
- IDLE -> CMP on in_valid && in_ready:
  - latch a, b, signed_mode;
  - chunk index idx=NCHUNK-1;
  - cycle count=0.
- CMP, one chunk per cycle on chunk idx:
  - In signed mode, the MSB of the top chunk (idx==NCHUNK-1) of both operands is inverted before unsigned chunk comparison. Lower chunks are always compared unsigned.
  - Chunk A > chunk B: register agtb=1, go to DONE.
  - Chunk A < chunk B: register altb=1, go to DONE.
  - Chunks equal and idx==0: register aeqb=1, go to DONE.
  - Chunks equal and idx>0: idx decrements, stay in CMP.
  - cycles increments on every CMP cycle.
- Latency: operand handshake at edge N; out_valid rises at edge N+k, where k = index of first differing chunk counted from the MSB, 1 <= k <= NCHUNK. Equal operands always take NCHUNK cycles.
- DONE:
  - out_valid=1; exactly one of agtb/altb/aeqb is high; cycles holds k.
  - Outputs are stable until the handshake.
  - On out_ready: go to IDLE and clear agtb/altb/aeqb/cycles. in_ready rises the cycle after.
  - out_ready held high before DONE has no effect and is not stored.
- in_valid outside IDLE is ignored; the upstream must hold operands until in_ready.
- flush (sync, any state): next state IDLE, outputs cleared as at reset. flush takes priority over both handshakes in the same cycle. reset_n takes priority over flush.
- Async reset mid-CMP or mid-DONE: the operation is lost and no result is produced.
- Degenerate CHUNK==WIDTH: NCHUNK=1; every compare is a single cycle.
- Result flags are registered outputs; no combinational path from a/b to the flags.

Decomposition:
- Shared package cmp_pkg:
  - state enum (IDLE, CMP, DONE);
  - result-code constants (GT, LT, EQ);
  - function for the signed MSB-bias of a chunk.
- One natural sub-module: chunk_cmp, a combinational CHUNK-bit unsigned compare producing gt/lt/eq with an msb_invert input. Instantiated once; the top-level holds the FSM, operand registers, index and counter.

Test Plan (WIDTH=32, CHUNK=8):
- Unsigned, a=0x12345678, b=0x12345677 -> out_valid 4 cycles after accept; agtb=1; cycles=4.
- Unsigned, a=0x10000000, b=0x20000000 -> altb=1 after 1 cycle (early termination); cycles=1.
- Signed, a=0xFFFFFFFF (-1), b=0x00000001 -> altb=1, cycles=1. Same operands unsigned -> agtb=1, cycles=1.
- Equal, a=b=0xDEADBEEF -> aeqb=1 after 4 cycles. out_ready held low 5 cycles -> flags and out_valid stable; in_ready=0 throughout.
- flush asserted during the 2nd CMP cycle of a=b=0xAAAAAAAA -> next cycle IDLE, in_ready=1, no out_valid. A new transaction then completes correctly.
- reset_n pulsed low mid-CMP (asynchronously, between edges) -> outputs immediately at reset values. Back-to-back transactions with out_ready tied high -> one result per transaction; in_ready re-asserts 1 cycle after each result.

Source files
------------

// File: rtl/cmp_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cmp_pkg
//  Purpose  : Shared types and helpers for the sequential magnitude comparator:
//             FSM state encoding, one-hot result codes {gt,lt,eq} and the
//             signed-mode MSB bias applied to the top chunk.
//  Revision : 1.0 - initial release
// ============================================================================
package cmp_pkg;

  // Comparator control states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Result codes, bit order matches the output triple {agtb, altb, aeqb}
  localparam logic [2:0] RES_NONE = 3'b000;
  localparam logic [2:0] RES_GT   = 3'b100;
  localparam logic [2:0] RES_LT   = 3'b010;
  localparam logic [2:0] RES_EQ   = 3'b001;

  // Flipping the sign bit maps two's-complement order onto unsigned order,
  // so the top chunk can be compared with a plain unsigned comparator.
  function automatic logic msb_bias(input logic msb, input logic invert);
    return msb ^ invert;
  endfunction

endpackage
`default_nettype wire

// File: rtl/chunk_cmp.sv
`default_nettype none
// ============================================================================
//  Module   : chunk_cmp
//  Purpose  : Combinational CHUNK-bit unsigned compare with optional MSB
//             inversion (used for the sign chunk in signed mode).
//  Revision : 1.0 - initial release
// ============================================================================
module chunk_cmp
  import cmp_pkg::*;
#(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             msb_invert,
  output logic             gt,
  output logic             lt,
  output logic             eq
);

  logic [CHUNK-1:0] w_a;
  logic [CHUNK-1:0] w_b;

  // Bias the MSB of both chunks when comparing the signed top chunk
  always_comb begin
    w_a            = a;
    w_b            = b;
    w_a[CHUNK-1]   = msb_bias(a[CHUNK-1], msb_invert);
    w_b[CHUNK-1]   = msb_bias(b[CHUNK-1], msb_invert);
  end

  assign gt = (w_a > w_b);
  assign lt = (w_a < w_b);
  assign eq = (w_a == w_b);

endmodule
`default_nettype wire

// File: rtl/seq_magnitude_comparator.sv
`default_nettype none
// ============================================================================
//  Module   : seq_magnitude_comparator
//  Purpose  : Multi-cycle WIDTH-bit magnitude comparator. Examines CHUNK bits
//             per clock, MSB chunk first, and finishes at the first chunk
//             that differs. Unsigned or signed per transaction, valid/ready
//             on both sides, registered result flags.
//  Revision : 1.0 - initial release
// ============================================================================
module seq_magnitude_comparator
  import cmp_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               flush,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [WIDTH-1:0]                   a,
  input  logic [WIDTH-1:0]                   b,
  input  logic                               signed_mode,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic                               agtb,
  output logic                               altb,
  output logic                               aeqb,
  output logic                               busy,
  output logic [$clog2(WIDTH/CHUNK+1)-1:0]   cycles
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int CNTW   = $clog2(NCHUNK + 1);
  localparam logic [IDXW-1:0] TOP_IDX = IDXW'(NCHUNK - 1);

  state_t            r_state, w_state_nxt;
  logic [WIDTH-1:0]  r_a, w_a_nxt;
  logic [WIDTH-1:0]  r_b, w_b_nxt;
  logic              r_signed, w_signed_nxt;
  logic [IDXW-1:0]   r_idx, w_idx_nxt;
  logic [CNTW-1:0]   r_cycles, w_cycles_nxt;
  logic [2:0]        r_res, w_res_nxt;

  logic              w_gt, w_lt, w_eq;
  logic              w_top;

  // The operand registers shift left each equal chunk, so the chunk under
  // test always sits in the top CHUNK bits; r_idx tracks which one it is.
  assign w_top = r_signed && (r_idx == TOP_IDX);

  chunk_cmp #(
    .CHUNK (CHUNK)
  ) u_chunk_cmp (
    .a          (r_a[WIDTH-1 -: CHUNK]),
    .b          (r_b[WIDTH-1 -: CHUNK]),
    .msb_invert (w_top),
    .gt         (w_gt),
    .lt         (w_lt),
    .eq         (w_eq)
  );

  // Next-state and next-datapath decode; flush overrides every handshake
  always_comb begin
    w_state_nxt  = r_state;
    w_a_nxt      = r_a;
    w_b_nxt      = r_b;
    w_signed_nxt = r_signed;
    w_idx_nxt    = r_idx;
    w_cycles_nxt = r_cycles;
    w_res_nxt    = r_res;

    if (flush) begin
      w_state_nxt  = IDLE;
      w_a_nxt      = '0;
      w_b_nxt      = '0;
      w_signed_nxt = 1'b0;
      w_idx_nxt    = '0;
      w_cycles_nxt = '0;
      w_res_nxt    = RES_NONE;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            w_state_nxt  = CMP;
            w_a_nxt      = a;
            w_b_nxt      = b;
            w_signed_nxt = signed_mode;
            w_idx_nxt    = TOP_IDX;
            w_cycles_nxt = '0;
          end
        end
        CMP: begin
          w_cycles_nxt = r_cycles + CNTW'(1);
          if (w_gt) begin
            w_res_nxt   = RES_GT;
            w_state_nxt = DONE;
          end else if (w_lt) begin
            w_res_nxt   = RES_LT;
            w_state_nxt = DONE;
          end else if (w_eq && (r_idx == '0)) begin
            w_res_nxt   = RES_EQ;
            w_state_nxt = DONE;
          end else begin
            w_idx_nxt = r_idx - IDXW'(1);
            w_a_nxt   = r_a << CHUNK;
            w_b_nxt   = r_b << CHUNK;
          end
        end
        DONE: begin
          if (out_ready) begin
            w_state_nxt  = IDLE;
            w_cycles_nxt = '0;
            w_res_nxt    = RES_NONE;
          end
        end
        default: begin
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Operand, index, counter and result registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_signed <= 1'b0;
      r_idx    <= '0;
      r_cycles <= '0;
      r_res    <= RES_NONE;
    end else begin
      r_a      <= w_a_nxt;
      r_b      <= w_b_nxt;
      r_signed <= w_signed_nxt;
      r_idx    <= w_idx_nxt;
      r_cycles <= w_cycles_nxt;
      r_res    <= w_res_nxt;
    end
  end

  assign in_ready            = (r_state == IDLE);
  assign out_valid           = (r_state == DONE);
  assign busy                = (r_state != IDLE);
  assign {agtb, altb, aeqb}  = r_res;
  assign cycles              = r_cycles;

endmodule
`default_nettype wire

// File: tb/tb_seq_magnitude_comparator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_magnitude_comparator
//  Purpose  : Self-checking bench: directed scenarios with literal
//             expectations plus a randomized run checked every cycle against
//             a transaction-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seq_magnitude_comparator;

  localparam int WIDTH  = 32;
  localparam int CHUNK  = 8;
  localparam int NCHUNK = WIDTH / CHUNK;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  a;
  logic [WIDTH-1:0]  b;
  logic              signed_mode;
  logic              out_valid;
  logic              out_ready;
  logic              agtb, altb, aeqb;
  logic              busy;
  logic [2:0]        cycles;

  int checks   = 0;
  int failures = 0;

  seq_magnitude_comparator #(
    .WIDTH (WIDTH),
    .CHUNK (CHUNK)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .signed_mode (signed_mode),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .agtb        (agtb),
    .altb        (altb),
    .aeqb        (aeqb),
    .busy        (busy),
    .cycles      (cycles)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Number of chunks examined: position of first differing chunk from the MSB
  function automatic int first_diff(input logic [31:0] x, input logic [31:0] y);
    for (int i = NCHUNK - 1; i >= 0; i--) begin
      if (x[i*CHUNK +: CHUNK] != y[i*CHUNK +: CHUNK]) return NCHUNK - i;
    end
    return NCHUNK;
  endfunction

  // Full-width reference result as {gt, lt, eq}
  function automatic logic [2:0] ref_res(input logic [31:0] x, input logic [31:0] y, input logic s);
    if (s) begin
      if ($signed(x) > $signed(y)) return 3'b100;
      if ($signed(x) < $signed(y)) return 3'b010;
      return 3'b001;
    end
    if (x > y) return 3'b100;
    if (x < y) return 3'b010;
    return 3'b001;
  endfunction

  // Transaction-level model: phase 0 idle, 1 comparing, 2 result held
  int         m_phase;
  int         m_k;
  int         m_left;
  logic [2:0] m_res;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_phase <= 0;
      m_k     <= 0;
      m_left  <= 0;
      m_res   <= 3'b000;
    end else if (flush) begin
      m_phase <= 0;
      m_k     <= 0;
      m_left  <= 0;
      m_res   <= 3'b000;
    end else begin
      case (m_phase)
        0: if (in_valid) begin
             m_phase <= 1;
             m_k     <= first_diff(a, b);
             m_left  <= first_diff(a, b);
             m_res   <= ref_res(a, b, signed_mode);
           end
        1: if (m_left == 1) m_phase <= 2;
           else m_left <= m_left - 1;
        default: if (out_ready) m_phase <= 0;
      endcase
    end
  end

  // Per-cycle compare of every output against the model
  always @(negedge clk) begin
    if (reset_n) begin
      check("in_ready",  {31'd0, in_ready},  {31'd0, m_phase == 0});
      check("out_valid", {31'd0, out_valid}, {31'd0, m_phase == 2});
      check("busy",      {31'd0, busy},      {31'd0, m_phase != 0});
      check("flags",     {29'd0, agtb, altb, aeqb}, (m_phase == 2) ? {29'd0, m_res} : 32'd0);
      check("cycles",    {29'd0, cycles},
            (m_phase == 2) ? m_k : ((m_phase == 1) ? (m_k - m_left) : 0));
    end
  end

  // One directed transaction from IDLE with literal expectations
  task automatic run_txn(input logic [31:0] ta, input logic [31:0] tb_v, input logic ts,
                         input logic [2:0] xres, input int xk, input int hold);
    int lat;
    bit seen;
    a = ta; b = tb_v; signed_mode = ts; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0; seen = 0;
    while (!seen && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (out_valid) seen = 1;
    end
    check("lit_latency", lat, xk);
    check("lit_flags", {29'd0, agtb, altb, aeqb}, {29'd0, xres});
    check("lit_cycles", {29'd0, cycles}, xk);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check("hold_in_ready", {31'd0, in_ready}, 32'd0);
      check("hold_out_valid", {31'd0, out_valid}, 32'd1);
      check("hold_flags", {29'd0, agtb, altb, aeqb}, {29'd0, xres});
      check("hold_cycles", {29'd0, cycles}, xk);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("post_in_ready", {31'd0, in_ready}, 32'd1);
    check("post_out_valid", {31'd0, out_valid}, 32'd0);
    check("post_flags", {29'd0, agtb, altb, aeqb}, 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout t=%0t", $time);
    $fatal(1);
  end

  initial begin
    logic [31:0] ra, rb;
    int j, nres, kpin;
    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; a = '0; b = '0;
    signed_mode = 1'b0; out_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_flags", {29'd0, agtb, altb, aeqb}, 32'd0);
    check("rst_cycles", {29'd0, cycles}, 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Pin the model helpers against hand-computed values
    kpin = first_diff(32'h10000000, 32'h20000000);
    check("model_k1", kpin, 1);
    kpin = first_diff(32'hDEADBEEF, 32'hDEADBEEF);
    check("model_keq", kpin, 4);
    check("model_signed", {29'd0, ref_res(32'hFFFFFFFF, 32'h1, 1'b1)}, 32'h2);

    // Directed scenarios
    run_txn(32'h12345678, 32'h12345677, 1'b0, 3'b100, 4, 0);
    run_txn(32'h10000000, 32'h20000000, 1'b0, 3'b010, 1, 0);
    run_txn(32'hFFFFFFFF, 32'h00000001, 1'b1, 3'b010, 1, 0);
    run_txn(32'hFFFFFFFF, 32'h00000001, 1'b0, 3'b100, 1, 0);
    run_txn(32'h80000000, 32'h7FFFFFFF, 1'b1, 3'b010, 1, 0);
    run_txn(32'h00FF0000, 32'h00800000, 1'b1, 3'b100, 2, 0);
    run_txn(32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 3'b001, 4, 5);

    // Flush in the second compare cycle
    a = 32'hAAAAAAAA; b = 32'hAAAAAAAA; signed_mode = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_in_ready", {31'd0, in_ready}, 32'd1);
    check("flush_busy", {31'd0, busy}, 32'd0);
    check("flush_cycles", {29'd0, cycles}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("flush_no_valid", {31'd0, out_valid}, 32'd0);
    end
    run_txn(32'h00000005, 32'h00000009, 1'b0, 3'b010, 4, 1);

    // Asynchronous reset between edges while comparing
    a = 32'h55555555; b = 32'h55555555; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #3;
    reset_n = 1'b0;
    #1;
    check("arst_in_ready", {31'd0, in_ready}, 32'd1);
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_out_valid", {31'd0, out_valid}, 32'd0);
    check("arst_cycles", {29'd0, cycles}, 32'd0);
    check("arst_flags", {29'd0, agtb, altb, aeqb}, 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("arst_no_valid", {31'd0, out_valid}, 32'd0);
    end

    // Back-to-back with out_ready tied high: three results in nine edges
    out_ready = 1'b1; in_valid = 1'b1;
    a = 32'h01000000; b = 32'h02000000; signed_mode = 1'b0;
    nres = 0;
    repeat (9) begin
      @(posedge clk); #1;
      if (out_valid) nres++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    check("b2b_results", nres, 3);
    check("b2b_in_ready", {31'd0, in_ready}, 32'd1);

    // Randomized traffic checked every cycle by the model
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      ra = $urandom;
      j  = $urandom_range(0, 5);
      rb = ra;
      if (j < 4) rb[j*CHUNK +: CHUNK] = 8'($urandom);
      else if (j == 5) rb = $urandom;
      a = ra; b = rb;
      signed_mode = 1'($urandom_range(0, 1));
      in_valid    = 1'($urandom_range(0, 1));
      out_ready   = ($urandom_range(0, 3) == 0);
      flush       = ($urandom_range(0, 63) == 0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("final_idle", {31'd0, in_ready}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
